// File: rtl/instr_fetch_pkg.sv
// Shared constants and entry type for the instruction fetch stage.
package instr_fetch_pkg;

  localparam logic [31:0] NOP_INSTR         = 32'h0000_0013;
  localparam logic [31:0] PC_INC            = 32'd4;
  localparam logic [31:0] DEFAULT_BOOT_ADDR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_fifo.sv
// Small {pc, instr} buffer between the memory response path and decode.
// Flush has priority; push and pop may coincide even when full.
module fetch_fifo
  import instr_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  output fetch_entry_t  head,
  output logic [CW-1:0] count,
  output logic          empty
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] wr_ptr_reg;

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count      <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count      <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr_reg] <= push_data;
        wr_ptr_reg      <= wr_ptr_reg + PW'(1);
      end
      if (pop) rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head  = mem[rd_ptr_reg];
  assign empty = (count == '0);

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: credit-limited req/gnt/rvalid fetch into a small FIFO feeding decode.
// Optional macro FETCH_MISALIGN_CHECK_EN halts on a misaligned redirect target.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR = DEFAULT_BOOT_ADDR,
  parameter int          DEPTH     = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        valid_o,
  input  logic        ready_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_misaligned_o
);

  localparam int CW = $clog2(DEPTH + 1);

  logic          started_reg;
  logic [31:0]   fetch_pc_reg, fetch_pc_next;
  logic [31:0]   resp_pc_reg, resp_pc_next;
  logic [CW-1:0] outstanding_reg, outstanding_next;
  logic [CW-1:0] discard_reg, discard_next;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty, fifo_push, fifo_pop;
  logic          credit_ok, grant, halted, halt_show;
  logic [31:0]   target_pc;
  fetch_entry_t  fifo_head, push_entry;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic halted_reg;

  assign target_pc = redirect_pc_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)         halted_reg <= 1'b0;
    else if (redirect_i) halted_reg <= (redirect_pc_i[1:0] != 2'b00);
  end

  assign halted    = halted_reg;
  // The trap pseudo-instruction appears only after stale responses have drained.
  assign halt_show = halted_reg && (discard_reg == '0);
`else
  assign target_pc = redirect_pc_i & 32'hFFFF_FFFC;
  assign halted    = 1'b0;
  assign halt_show = 1'b0;
`endif

  // Buffered words plus in-flight requests never exceed DEPTH.
  assign credit_ok   = ({1'b0, fifo_count} + {1'b0, outstanding_reg}) < (CW + 1)'(DEPTH);
  assign imem_req_o  = started_reg && !halted && credit_ok;
  assign imem_addr_o = fetch_pc_reg;
  assign grant       = imem_req_o && imem_gnt_i;

  assign outstanding_next = outstanding_reg + CW'(grant) - CW'(imem_rvalid_i);

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    resp_pc_next  = resp_pc_reg;
    discard_next  = discard_reg;
    fifo_push     = 1'b0;
    if (grant) fetch_pc_next = fetch_pc_reg + PC_INC;
    if (imem_rvalid_i) begin
      if (discard_reg != '0) begin
        discard_next = discard_reg - CW'(1);
      end else begin
        fifo_push    = 1'b1;
        resp_pc_next = resp_pc_reg + PC_INC;
      end
    end
    // Everything still in flight after this cycle belongs to the old path.
    if (redirect_i) begin
      fetch_pc_next = target_pc;
      resp_pc_next  = target_pc;
      discard_next  = outstanding_next;
      fifo_push     = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      started_reg     <= 1'b0;
      fetch_pc_reg    <= BOOT_ADDR;
      resp_pc_reg     <= BOOT_ADDR;
      outstanding_reg <= '0;
      discard_reg     <= '0;
    end else begin
      started_reg     <= 1'b1;
      fetch_pc_reg    <= fetch_pc_next;
      resp_pc_reg     <= resp_pc_next;
      outstanding_reg <= outstanding_next;
      discard_reg     <= discard_next;
    end
  end

  assign push_entry = '{pc: resp_pc_reg, instr: imem_rdata_i};
  assign fifo_pop   = !fifo_empty && ready_i && !redirect_i;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .flush     (redirect_i),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign valid_o            = !fifo_empty || halt_show;
  assign instr_o            = halt_show ? NOP_INSTR : fifo_head.instr;
  assign pc_o               = halt_show ? fetch_pc_reg : fifo_head.pc;
  assign instr_misaligned_o = halt_show;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch (DEPTH=2) with an in-order memory model.
// Define FETCH_MISALIGN_CHECK_EN for both bench and RTL to check the halt path.
module tb_instr_fetch;

  localparam int DEPTH = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'h0;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        instr_misaligned_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] q[$];

  always #5 clk_i = ~clk_i;

  instr_fetch #(.BOOT_ADDR(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .imem_req_o         (imem_req_o),
    .imem_addr_o        (imem_addr_o),
    .imem_gnt_i         (imem_gnt_i),
    .imem_rvalid_i      (imem_rvalid_i),
    .imem_rdata_i       (imem_rdata_i),
    .instr_o            (instr_o),
    .pc_o               (pc_o),
    .valid_o            (valid_o),
    .ready_i            (ready_i),
    .redirect_i         (redirect_i),
    .redirect_pc_i      (redirect_pc_i),
    .instr_misaligned_o (instr_misaligned_o)
  );

  typedef struct {
    logic        gnt;
    logic        rv;
    logic        rdy;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vt [14];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  function automatic vec_t mk(input logic g, input logic rv, input logic rdy,
                              input logic ereq, input logic [31:0] eaddr,
                              input logic evalid, input logic [31:0] epc);
    vec_t v;
    v.gnt = g; v.rv = rv; v.rdy = rdy;
    v.exp_req = ereq; v.exp_addr = eaddr;
    v.exp_valid = evalid; v.exp_pc = epc;
    return v;
  endfunction

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // One clock: drive inputs at the falling edge, update the memory model at the rising edge.
  task automatic step(input logic g, input logic rv, input logic rdy,
                      input logic rd, input logic [31:0] rpc);
    logic        req_s;
    logic        rv_s;
    logic [31:0] addr_s;
    imem_gnt_i    = g;
    ready_i       = rdy;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    rv_s          = rv && (q.size() > 0);
    imem_rvalid_i = rv_s;
    imem_rdata_i  = rv_s ? mem_word(q[0]) : 32'h0;
    req_s         = imem_req_o;
    addr_s        = imem_addr_o;
    @(posedge clk_i);
    if (rv_s) void'(q.pop_front());
    if (req_s && g) q.push_back(addr_s);
    @(negedge clk_i);
  endtask

  task automatic consume(input string tag, input logic [31:0] start, input int n);
    logic [31:0] exp;
    int got;
    int cyc;
    exp = start;
    got = 0;
    cyc = 0;
    while (got < n && cyc < 60) begin
      if (valid_o) begin
        check32({tag, "_pc"}, pc_o, exp);
        check32({tag, "_instr"}, instr_o, mem_word(exp));
        check1({tag, "_misaligned"}, instr_misaligned_o, 1'b0);
        $display("%s word %0d pc=%08h instr=%08h", tag, got, pc_o, instr_o);
        exp = exp + 32'd4;
        got++;
      end
      step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      cyc++;
    end
    checks++;
    if (got < n) begin
      errors++;
      $display("FAIL %s_timeout: got %0d words expected %0d", tag, got, n);
    end
  endtask

  task automatic quiesce();
    repeat (8) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stall_grants;
    logic q_ok;

    vt[0]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0);
    vt[1]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 32'h0,  1'b0, 32'h0);
    vt[2]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 32'h4,  1'b0, 32'h0);
    vt[3]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 32'h0);
    vt[4]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 32'h8,  1'b1, 32'h4);
    vt[5]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 32'hC,  1'b0, 32'h0);
    vt[6]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 32'h8);
    vt[7]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'hC);
    vt[8]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 32'h14, 1'b0, 32'h0);
    vt[9]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h10);
    vt[10] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h10);
    vt[11] = mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 32'h10);
    vt[12] = mk(1'b1, 1'b1, 1'b1, 1'b1, 32'h18, 1'b1, 32'h14);
    vt[13] = mk(1'b1, 1'b1, 1'b1, 1'b1, 32'h1C, 1'b0, 32'h0);

    // Reset state.
    repeat (2) @(negedge clk_i);
    check1("rst_valid", valid_o, 1'b0);
    check1("rst_req", imem_req_o, 1'b0);
    check32("rst_instr", instr_o, 32'h0);
    check32("rst_pc", pc_o, 32'h0);
    check1("rst_misaligned", instr_misaligned_o, 1'b0);
    $display("reset valid=%0b req=%0b pc=%08h", valid_o, imem_req_o, pc_o);
    rst_ni = 1'b1;

    // Boot sequence and short stall, cycle by cycle.
    for (int i = 0; i < 14; i++) begin
      check1($sformatf("t%0d_req", i), imem_req_o, vt[i].exp_req);
      if (vt[i].exp_req) check32($sformatf("t%0d_addr", i), imem_addr_o, vt[i].exp_addr);
      check1($sformatf("t%0d_valid", i), valid_o, vt[i].exp_valid);
      if (vt[i].exp_valid) begin
        check32($sformatf("t%0d_pc", i), pc_o, vt[i].exp_pc);
        check32($sformatf("t%0d_instr", i), instr_o, mem_word(vt[i].exp_pc));
      end
      $display("vec %0d req=%0b addr=%08h valid=%0b pc=%08h", i, imem_req_o, imem_addr_o, valid_o, pc_o);
      step(vt[i].gnt, vt[i].rv, vt[i].rdy, 1'b0, 32'h0);
    end

    // Long decode stall: credits stop requests, head word holds.
    stall_grants = 0;
    q_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check1("stall_valid", valid_o, 1'b1);
      check32("stall_pc", pc_o, 32'h18);
      if (imem_req_o) stall_grants++;
      if (q.size() > DEPTH) q_ok = 1'b0;
      $display("stall %0d req=%0b pc=%08h inflight=%0d", i, imem_req_o, pc_o, q.size());
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    end
    check1("stall_grants_le_depth", stall_grants <= DEPTH, 1'b1);
    check1("stall_inflight_le_depth", q_ok, 1'b1);
    consume("resume", 32'h18, 6);

    // Redirect with two requests outstanding.
    quiesce();
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    check1("two_out_req", imem_req_o, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h100);
    check1("redir_r1_valid", valid_o, 1'b0);
    consume("redir", 32'h100, 3);

    // Redirect coinciding with rvalid and a pop.
    quiesce();
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    check1("rvpop_setup_valid", valid_o, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h300);
    check1("rvpop_r1_valid", valid_o, 1'b0);
    check1("rvpop_r1_req", imem_req_o, 1'b1);
    check32("rvpop_r1_addr", imem_addr_o, 32'h300);
    consume("rvpop", 32'h300, 3);

    // Address wrap.
    quiesce();
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    check1("wrap_req0", imem_req_o, 1'b1);
    check32("wrap_addr0", imem_addr_o, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    check1("wrap_req1", imem_req_o, 1'b1);
    check32("wrap_addr1", imem_addr_o, 32'h0);
    consume("wrap", 32'hFFFF_FFFC, 3);

    // Misaligned redirect target.
    quiesce();
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h102);
`ifdef FETCH_MISALIGN_CHECK_EN
    for (int i = 0; i < 3; i++) begin
      check1("misal_req", imem_req_o, 1'b0);
      check1("misal_valid", valid_o, 1'b1);
      check1("misal_flag", instr_misaligned_o, 1'b1);
      check32("misal_pc", pc_o, 32'h102);
      check32("misal_instr", instr_o, 32'h0000_0013);
      $display("misal %0d valid=%0b flag=%0b pc=%08h", i, valid_o, instr_misaligned_o, pc_o);
      step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    end
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h200);
    check1("misal_clear_flag", instr_misaligned_o, 1'b0);
    consume("misal_resume", 32'h200, 3);
`else
    check1("misal_flag", instr_misaligned_o, 1'b0);
    check1("misal_req", imem_req_o, 1'b1);
    check32("misal_addr", imem_addr_o, 32'h100);
    consume("misal", 32'h100, 3);
`endif

    // Back-to-back redirects with grants and a response in between.
    quiesce();
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'h400);
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h500);
    check1("b2b_r1_valid", valid_o, 1'b0);
    consume("b2b", 32'h500, 3);

    // Mid-operation reset with requests in flight.
    rst_ni = 1'b0;
    #1;
    check1("mid_rst_valid", valid_o, 1'b0);
    check1("mid_rst_req", imem_req_o, 1'b0);
    check32("mid_rst_pc", pc_o, 32'h0);
    check32("mid_rst_instr", instr_o, 32'h0);
    $display("mid reset valid=%0b req=%0b", valid_o, imem_req_o);
    q.delete();
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b0;
    redirect_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    check1("post_rst_req0", imem_req_o, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    check1("post_rst_req1", imem_req_o, 1'b1);
    check32("post_rst_addr", imem_addr_o, 32'h0);
    consume("post_rst", 32'h0, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
